// File: rtl/adder_control_sequencer.sv
// Fetch/decode/execute control FSM for the adding machine: drives PC strobes,
// MAR/memory read sequencing with a bounded ready wait, IR and accumulator loads.
module adder_control_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WAIT_W     = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] ir_in,
   input  logic       mem_ready,
   output logic       clear_pc,
   output logic       load_pc,
   output logic       inc_pc,
   output logic [5:0] data_out_pc,
   output logic       load_mar,
   output logic       mar_sel,
   output logic       mem_rd,
   output logic       load_ir,
   output logic       load_acc,
   output logic       acc_add,
   output logic       busy,
   output logic       halted,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_F_ADDR,
      S_F_WAIT,
      S_DECODE,
      S_X_ADDR,
      S_X_WAIT,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [1:0] OP_LDA = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_HLT = 2'b11;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [1:0]          opcode;

   assign opcode = ir_in[7:6];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = '0;
      clear_pc    = 1'b0;
      load_pc     = 1'b0;
      inc_pc      = 1'b0;
      data_out_pc = ir_in[5:0];
      load_mar    = 1'b0;
      mar_sel     = 1'b0;
      mem_rd      = 1'b0;
      load_ir     = 1'b0;
      load_acc    = 1'b0;
      acc_add     = 1'b0;
      busy        = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;

      // wait_d defaults to zero, so every path into a wait state starts at index 0
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               clear_pc = 1'b1;
               state_d  = S_F_ADDR;
            end
         end
         S_F_ADDR: begin
            busy     = 1'b1;
            load_mar = 1'b1;
            state_d  = S_F_WAIT;
         end
         S_F_WAIT: begin
            busy   = 1'b1;
            mem_rd = 1'b1;
            if (mem_ready) begin
               load_ir = 1'b1;
               inc_pc  = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_W'(WAIT_LIMIT)) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            busy = 1'b1;
            unique case (opcode)
               OP_LDA, OP_ADD: state_d = S_X_ADDR;
               OP_JMP: begin
                  load_pc = 1'b1;
                  state_d = S_F_ADDR;
               end
               OP_HLT: state_d = S_HALT;
               default: state_d = S_HALT;
            endcase
         end
         S_X_ADDR: begin
            busy     = 1'b1;
            load_mar = 1'b1;
            mar_sel  = 1'b1;
            state_d  = S_X_WAIT;
         end
         S_X_WAIT: begin
            busy   = 1'b1;
            mem_rd = 1'b1;
            if (mem_ready) begin
               load_acc = 1'b1;
               acc_add  = (opcode == OP_ADD);
               state_d  = S_F_ADDR;
            end else if (wait_q == WAIT_W'(WAIT_LIMIT)) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) begin
               clear_pc = 1'b1;
               state_d  = S_F_ADDR;
            end
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are combinational, so an asserted reset must mask them directly
      if (!reset) begin
         clear_pc    = 1'b0;
         load_pc     = 1'b0;
         inc_pc      = 1'b0;
         data_out_pc = '0;
         load_mar    = 1'b0;
         mar_sel     = 1'b0;
         mem_rd      = 1'b0;
         load_ir     = 1'b0;
         load_acc    = 1'b0;
         acc_add     = 1'b0;
         busy        = 1'b0;
         halted      = 1'b0;
         fault       = 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_control_sequencer.sv
// Directed bench for adder_control_sequencer with a small PC/MAR/IR/ACC/memory
// environment driven by the sequencer's strobes.
module tb_adder_control_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] ir_in;
   logic       mem_ready = 1'b0;
   logic       clear_pc, load_pc, inc_pc;
   logic [5:0] data_out_pc;
   logic       load_mar, mar_sel, mem_rd, load_ir, load_acc, acc_add;
   logic       busy, halted, fault;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [64];
   logic [5:0] pc     = 6'h15;
   logic [5:0] mar    = 6'h3F;
   logic [7:0] ir_reg = 8'h00;
   logic [7:0] acc    = 8'h00;

   assign ir_in = ir_reg;

   adder_control_sequencer #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
      .clock(clock), .reset(reset), .start(start), .ir_in(ir_in),
      .mem_ready(mem_ready), .clear_pc(clear_pc), .load_pc(load_pc),
      .inc_pc(inc_pc), .data_out_pc(data_out_pc), .load_mar(load_mar),
      .mar_sel(mar_sel), .mem_rd(mem_rd), .load_ir(load_ir),
      .load_acc(load_acc), .acc_add(acc_add), .busy(busy),
      .halted(halted), .fault(fault)
   );

   always #5 clock = ~clock;

   // Environment: program counter, MAR, IR and accumulator
   always @(posedge clock) begin
      if (clear_pc)     pc <= 6'd0;
      else if (load_pc) pc <= data_out_pc;
      else if (inc_pc)  pc <= pc + 6'd1;
      if (load_mar) mar <= mar_sel ? ir_in[5:0] : pc;
      if (load_ir)  ir_reg <= mem[mar];
      if (load_acc) acc <= acc_add ? acc + mem[mar] : mem[mar];
   end

   task automatic cyc(input logic st, input logic rdy);
      @(posedge clock);
      #1;
      start     = st;
      mem_ready = rdy;
      @(negedge clock);
   endtask

   task automatic do_reset();
      #1;
      reset     = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic load_prog(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[0] = w0;
      mem[1] = w1;
      mem[2] = w2;
   endtask

   function automatic logic [18:0] all_out();
      return {clear_pc, load_pc, inc_pc, data_out_pc, load_mar, mar_sel, mem_rd,
              load_ir, load_acc, acc_add, busy, halted, fault};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      #3;
      checks++;
      if ({clear_pc, busy, halted, fault} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_low_outputs got=%b exp=0000", {clear_pc, busy, halted, fault});
      end
      do_reset();
      cyc(1'b0, 1'b0);
      checks++;
      if ({clear_pc, load_mar, mem_rd, busy, halted, fault} !== 6'b0) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=000000", {clear_pc, load_mar, mem_rd, busy, halted, fault});
      end
   endtask

   task automatic test_program();
      int inc_cnt = 0, acc_cnt = 0, xa_cnt = 0;
      logic [1:0] add_seq = 2'b00;
      load_prog(8'h05, 8'h46, 8'hC0);
      mem[5] = 8'h11;
      mem[6] = 8'h22;
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         cyc(c == 0, 1'b1);
         if (c == 0) begin
            checks++;
            if (clear_pc !== 1'b1) begin
               errors++;
               $display("FAIL prog_clear_pc got=%b exp=1", clear_pc);
            end
         end
         if (inc_pc) inc_cnt++;
         if (load_mar && mar_sel) xa_cnt++;
         if (load_acc) begin
            add_seq = {add_seq[0], acc_add};
            acc_cnt++;
         end
         if (c == 13) begin
            checks++;
            if (halted !== 1'b0) begin
               errors++;
               $display("FAIL prog_halted_c13 got=%b exp=0", halted);
            end
         end
         if (c == 14) begin
            checks++;
            if (halted !== 1'b1) begin
               errors++;
               $display("FAIL prog_halted_c14 got=%b exp=1", halted);
            end
         end
      end
      checks++;
      if (inc_cnt != 3) begin
         errors++;
         $display("FAIL prog_inc_count got=%0d exp=3", inc_cnt);
      end
      checks++;
      if (acc_cnt != 2 || add_seq !== 2'b01) begin
         errors++;
         $display("FAIL prog_load_acc got=%0d/%b exp=2/01", acc_cnt, add_seq);
      end
      checks++;
      if (xa_cnt != 2) begin
         errors++;
         $display("FAIL prog_xaddr_sel got=%0d exp=2", xa_cnt);
      end
      checks++;
      if (acc !== 8'h33) begin
         errors++;
         $display("FAIL prog_acc got=%0h exp=33", acc);
      end
   endtask

   task automatic test_jump();
      load_prog(8'hAA, 8'h00, 8'h00);
      mem[6'h2A] = 8'hC0;
      do_reset();
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if ({load_pc, data_out_pc, inc_pc} !== {1'b1, 6'h2A, 1'b0}) begin
         errors++;
         $display("FAIL jmp_decode got=%b/%0h/%b exp=1/2a/0", load_pc, data_out_pc, inc_pc);
      end
      cyc(1'b0, 1'b1);
      checks++;
      if ({load_mar, mar_sel} !== 2'b10) begin
         errors++;
         $display("FAIL jmp_faddr got=%b exp=10", {load_mar, mar_sel});
      end
      cyc(1'b0, 1'b1);
      checks++;
      if (mar !== 6'h2A) begin
         errors++;
         $display("FAIL jmp_mar got=%0h exp=2a", mar);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL jmp_halt got=%b exp=1", halted);
      end
   endtask

   task automatic test_wait_states();
      int rd_cnt = 0, ir_cnt = 0, inc_cnt = 0, busy_bad = 0;
      load_prog(8'hC0, 8'h00, 8'h00);
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         cyc(c == 0, c == 5);
         if (mem_rd) rd_cnt++;
         if (load_ir) ir_cnt++;
         if (inc_pc) inc_cnt++;
         if (c >= 1 && busy !== 1'b1) busy_bad++;
         if (c == 5) begin
            checks++;
            if ({load_ir, inc_pc} !== 2'b11) begin
               errors++;
               $display("FAIL wait_accept_cycle got=%b exp=11", {load_ir, inc_pc});
            end
         end
      end
      checks++;
      if (rd_cnt != 4 || ir_cnt != 1 || inc_cnt != 1) begin
         errors++;
         $display("FAIL wait_counts got=%0d/%0d/%0d exp=4/1/1", rd_cnt, ir_cnt, inc_cnt);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL wait_busy got=%0d exp=0", busy_bad);
      end
   endtask

   task automatic test_fault();
      int rd_cnt = 0;
      load_prog(8'h05, 8'h00, 8'h00);
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         cyc(c == 0, 1'b0);
         if (mem_rd) rd_cnt++;
         if (c == 17) begin
            checks++;
            if ({fault, busy} !== 2'b01) begin
               errors++;
               $display("FAIL fault_c17 got=%b exp=01", {fault, busy});
            end
         end
         if (c == 18) begin
            checks++;
            if ({fault, busy, mem_rd} !== 3'b100) begin
               errors++;
               $display("FAIL fault_entry got=%b exp=100", {fault, busy, mem_rd});
            end
         end
      end
      checks++;
      if (rd_cnt != 16) begin
         errors++;
         $display("FAIL fault_wait_cycles got=%0d exp=16", rd_cnt);
      end
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      checks++;
      if ({fault, clear_pc, busy} !== 3'b100) begin
         errors++;
         $display("FAIL fault_start_ignored got=%b exp=100", {fault, clear_pc, busy});
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (all_out() !== 19'd0) begin
         errors++;
         $display("FAIL fault_reset_outputs got=%0h exp=0", all_out());
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({fault, busy, clear_pc} !== 3'b000) begin
         errors++;
         $display("FAIL fault_back_idle got=%b exp=000", {fault, busy, clear_pc});
      end
   endtask

   task automatic test_async_reset();
      load_prog(8'h05, 8'h00, 8'h00);
      do_reset();
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL async_xwait_rd got=%b exp=1", mem_rd);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_rd, busy} !== 2'b00) begin
         errors++;
         $display("FAIL async_rd_drop got=%b exp=00", {mem_rd, busy});
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(1'b1, 1'b1);
      checks++;
      if (clear_pc !== 1'b1) begin
         errors++;
         $display("FAIL async_restart_clear got=%b exp=1", clear_pc);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if (mar !== 6'd0 || mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL async_fetch_addr got=%0h/%b exp=0/1", mar, mem_rd);
      end
   endtask

   task automatic test_back_to_back();
      load_prog(8'hC0, 8'h00, 8'h00);
      do_reset();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      checks++;
      if ({clear_pc, mem_rd} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_start_in_fwait got=%b exp=01", {clear_pc, mem_rd});
      end
      cyc(1'b1, 1'b1);
      checks++;
      if ({clear_pc, inc_pc} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_fetch_accept got=%b exp=01", {clear_pc, inc_pc});
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      checks++;
      if ({halted, clear_pc} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_halt_restart got=%b exp=11", {halted, clear_pc});
      end
      cyc(1'b0, 1'b1);
      checks++;
      if ({halted, load_mar, mar_sel} !== 3'b010) begin
         errors++;
         $display("FAIL b2b_rerun_faddr got=%b exp=010", {halted, load_mar, mar_sel});
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      checks++;
      if (halted !== 1'b1 || pc !== 6'd1) begin
         errors++;
         $display("FAIL b2b_rerun_halt got=%b/%0d exp=1/1", halted, pc);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_jump();
      test_wait_states();
      test_fault();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
